alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor of the 4-bit combinational ALU. It selects one of eight operations with up/down push buttons: the button inputs are synchronised and edge-detected, and the selection steps once per press. Operands are captured on a valid strobe, and the result and flags are returned one cycle later. It sits between the board switch/button inputs and the LED/segment display logic.

## Interface
- WIDTH, 4: operand/result width in bits, two's-complement, ≥2.
- SATURATE, 1: op-select behaviour at the ends; 1 = clamp at 0/7, 0 = wrap 7→0 and 0→7.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, synchronous and active-high.
- control_up  input  1  raw button, asynchronous to clk.
- control_down  input  1  raw button, asynchronous to clk.
- in_valid  input  1  operands valid this cycle.
- a  input  WIDTH  operand A, two's-complement.
- b  input  WIDTH  operand B, two's-complement.
- control_led  output  3  current op code.
- out_valid  output  1  result/flags valid, one-cycle pulse per accepted operation.
- result  output  WIDTH  registered result.
- carry  output  1  registered carry flag.
- zero  output  1  registered zero flag.
- overflow  output  1  registered signed-overflow flag.

## Operation
- Button path
  - Each button passes through a 2-FF synchroniser, then a previous-value register.
  - A press is the synchronised value going 1 while the previous value is 0.
  - A held button gives exactly one step.
- Op-select register (reset 0, drives control_led)
  - Up press only: +1. At 7, stays 7 if SATURATE=1; wraps to 0 if SATURATE=0.
  - Down press only: −1. At 0, stays 0 if SATURATE=1; wraps to 7 if SATURATE=0.
  - Up and down press in the same cycle: no change.
- Ops. The sum is a + b; the difference is computed as a + ~b + 1, WIDTH+1 bits wide.
  - 0 add: result = sum[WIDTH-1:0]; carry = sum[WIDTH].
  - 1 sub: result = a − b; carry = carry-out of a + ~b + 1 (1 = no borrow).
  - 2 not: result = ~a.
  - 3 and: result = a & b.
  - 4 or: result = a | b.
  - 5 xor: result = a ^ b.
  - 6 signed less-than: result = {0…, (a <s b)}.
  - 7 equal: result = {0…, (a == b)}.
- Flags
  - zero = (result == 0) for all ops.
  - overflow (add) = a[MSB] == b[MSB] and result[MSB] != a[MSB].
  - overflow (sub) = a[MSB] != b[MSB] and result[MSB] != a[MSB].
  - Ops 2–7: carry = 0 and overflow = 0.
- Capture
  - On an edge with in_valid=1, a, b and the current op-select value are used.
  - An op change made on that same edge does not apply until the next capture.
  - On edges with in_valid=0, result and flags hold their last value.

## Timing
- Reset: control_led=0, out_valid=0, result=0, carry=0, zero=0, overflow=0.
  - Synchroniser and previous-value registers also reset to 0.
  - A button held through reset gives no step after reset releases: the previous-value register reloads through the synchroniser before an edge can be seen.
- Button latency: raw input first sampled high at edge k gives the control_led update at edge k+2. Released low for ≥3 cycles re-arms the detector.
- Datapath latency: 1 cycle. in_valid at edge n gives out_valid=1 with result/flags after edge n, held until edge n+1.
  - Back-to-back in_valid gives one result per cycle. There is no backpressure.
- rst=1 mid-operation: out_valid is 0 after that edge, and the pending result is discarded.

## Test plan
- Add overflow (WIDTH=4, op 0): a=0111, b=0001, in_valid one cycle → next cycle: out_valid=1, result=1000, overflow=1, carry=0, zero=0.
- Subtract equal (op 1): a=0011, b=0011 → result=0000, zero=1, carry=1, overflow=0.
  - Then a=1000, b=0001 → result=0111, overflow=1.
- Signed compare (op 6): a=1000 (−8), b=0001 → result=0001.
  - Then a=0001, b=1000 → result=0000, zero=1.
- Saturation (SATURATE=1): 9 separate up presses from reset → control_led=7; then 9 down presses → 0.
  - With SATURATE=0: 8 up presses from reset → 0; one down press from 0 → 7.
- Button hygiene:
  - up held 20 cycles → control_led +1 exactly once, 2 edges after first sample.
  - up and down pressed in the same cycle → no change.
  - rst pulsed while up is held → control_led=0 and stays 0 until up is released and pressed again.
- Streaming: in_valid high 4 consecutive cycles, op 3 (and), with a=1111 and b stepping 0001, 0010, 0100, 1000.
  - Results 0001, 0010, 0100, 1000 appear on 4 consecutive cycles with out_valid high.
  - out_valid drops to 0 the cycle after in_valid drops.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with an op selector stepped by push buttons.
//
// Each push button passes through a 2-FF synchroniser and a previous-value
// register, then a rising-edge detector. Each press steps a 3-bit op-select
// register up or down. The op-select register either clamps or wraps at its
// ends. Operands are captured on i_in_valid together with the current
// op-select value. The result and flags are registered and appear one
// cycle later.
//
// Ports:
//   i_clk           clock, all state changes on the rising edge
//   i_rst           synchronous active-high reset
//   i_control_up    raw "up" button, asynchronous to i_clk
//   i_control_down  raw "down" button, asynchronous to i_clk
//   i_in_valid      operands valid this cycle
//   i_a, i_b        WIDTH-bit two's-complement operands
//   o_control_led   current op code (0..7)
//   o_out_valid     one-cycle pulse per accepted operation
//   o_result        registered result
//   o_carry         registered carry flag (sub: 1 = no borrow)
//   o_zero          registered zero flag
//   o_overflow      registered signed-overflow flag
module alu_seq #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_control_up,
  input  logic             i_control_down,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [2:0]       o_control_led,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_overflow
);

  logic r_sync1_up, r_sync2_up, r_prev_up;
  logic r_sync1_dn, r_sync2_dn, r_prev_dn;
  logic [1:0] r_arm;
  logic [2:0] r_op;
  logic w_armed, w_up_press, w_dn_press;
  logic [2:0] w_op_next;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry, r_zero, r_overflow;

  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry, w_overflow, w_lt;

  // Synchronisers, previous-value registers and post-reset arming counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1_up <= 1'b0;
      r_sync2_up <= 1'b0;
      r_prev_up  <= 1'b0;
      r_sync1_dn <= 1'b0;
      r_sync2_dn <= 1'b0;
      r_prev_dn  <= 1'b0;
      r_arm      <= 2'd0;
    end else begin
      r_sync1_up <= i_control_up;
      r_sync2_up <= r_sync1_up;
      r_prev_up  <= r_sync2_up;
      r_sync1_dn <= i_control_down;
      r_sync2_dn <= r_sync1_dn;
      r_prev_dn  <= r_sync2_dn;
      if (r_arm != 2'd3) begin
        r_arm <= r_arm + 2'd1;
      end
    end
  end

  // Edge detection stays masked until a button level held through reset has
  // reached the previous-value register. Otherwise that level would look
  // like a fresh press.
  assign w_armed    = (r_arm == 2'd3);
  assign w_up_press = w_armed & r_sync2_up & ~r_prev_up;
  assign w_dn_press = w_armed & r_sync2_dn & ~r_prev_dn;

  // Next op-select value: step once per press, clamp or wrap at the ends.
  always_comb begin
    w_op_next = r_op;
    case ({w_up_press, w_dn_press})
      2'b10: begin
        if (r_op == 3'd7) begin
          w_op_next = SATURATE ? 3'd7 : 3'd0;
        end else begin
          w_op_next = r_op + 3'd1;
        end
      end
      2'b01: begin
        if (r_op == 3'd0) begin
          w_op_next = SATURATE ? 3'd0 : 3'd7;
        end else begin
          w_op_next = r_op - 3'd1;
        end
      end
      default: w_op_next = r_op;
    endcase
  end

  // Op-select register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op <= 3'd0;
    end else begin
      r_op <= w_op_next;
    end
  end

  // The difference is formed as a + ~b + 1, so its top bit is the no-borrow
  // carry.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_lt   = ($signed(i_a) < $signed(i_b));

  // Combinational ALU for the currently selected op.
  always_comb begin
    w_res      = {WIDTH{1'b0}};
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (r_op)
      3'd0: begin
        w_res      = w_sum[WIDTH-1:0];
        w_carry    = w_sum[WIDTH];
        w_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      3'd1: begin
        w_res      = w_diff[WIDTH-1:0];
        w_carry    = w_diff[WIDTH];
        w_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      3'd2: w_res = ~i_a;
      3'd3: w_res = i_a & i_b;
      3'd4: w_res = i_a | i_b;
      3'd5: w_res = i_a ^ i_b;
      3'd6: w_res = {{(WIDTH-1){1'b0}}, w_lt};
      3'd7: w_res = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
      default: w_res = {WIDTH{1'b0}};
    endcase
  end

  // Output registers: capture on in_valid, otherwise hold the last result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= i_in_valid;
      if (i_in_valid) begin
        r_result   <= w_res;
        r_carry    <= w_carry;
        r_zero     <= (w_res == {WIDTH{1'b0}});
        r_overflow <= w_overflow;
      end
    end
  end

  assign o_control_led = r_op;
  assign o_out_valid   = r_out_valid;
  assign o_result      = r_result;
  assign o_carry       = r_carry;
  assign o_zero        = r_zero;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq.
// Two instances share all inputs: one clamps its op selector and one wraps it.
// The datapath is checked on the clamping instance.
module tb_alu_seq;
  localparam int W = 4;

  logic clk, rst, up, dn, in_valid;
  logic [W-1:0] a, b;
  logic [2:0] led_s, led_w;
  logic ov_s, ov_w, c_s, c_w, z_s, z_w, v_s, v_w;
  logic [W-1:0] r_s, r_w;

  int n_vec = 0;
  int n_err = 0;
  int op_sat = 0;
  int op_wrap = 0;

  alu_seq #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_control_up(up), .i_control_down(dn),
    .i_in_valid(in_valid), .i_a(a), .i_b(b), .o_control_led(led_s),
    .o_out_valid(ov_s), .o_result(r_s), .o_carry(c_s), .o_zero(z_s),
    .o_overflow(v_s));

  alu_seq #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
    .i_clk(clk), .i_rst(rst), .i_control_up(up), .i_control_down(dn),
    .i_in_valid(in_valid), .i_a(a), .i_b(b), .o_control_led(led_w),
    .o_out_valid(ov_w), .o_result(r_w), .o_carry(c_w), .o_zero(z_w),
    .o_overflow(v_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic c;
    logic z;
    logic v;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic: returns {res, c, z, v}.
  function automatic logic [W+2:0] ref_alu(input int op, input logic [W-1:0] ra,
                                           input logic [W-1:0] rb);
    int ua, ub, sa, sb, t, r;
    logic c, v;
    ua = int'(ra);
    ub = int'(rb);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin
        r = (ua + ub) % (1 << W);
        c = ((ua + ub) >= (1 << W));
        t = sa + sb;
        v = (t > (1 << (W - 1)) - 1) || (t < -(1 << (W - 1)));
      end
      1: begin
        r = (ua - ub + (1 << W)) % (1 << W);
        c = (ua >= ub);
        t = sa - sb;
        v = (t > (1 << (W - 1)) - 1) || (t < -(1 << (W - 1)));
      end
      2: r = (1 << W) - 1 - ua;
      3: r = int'(ra & rb);
      4: r = int'(ra | rb);
      5: r = int'(ra ^ rb);
      6: r = (sa < sb) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    return {r[W-1:0], c, (r == 0), v};
  endfunction

  function automatic int step(input int op, input bit pu, input bit pd, input bit sat);
    int n;
    n = op;
    if (pu && !pd) n = op + 1;
    if (pd && !pu) n = op - 1;
    if (sat) begin
      if (n > 7) n = 7;
      if (n < 0) n = 0;
    end else begin
      n = (n + 8) % 8;
    end
    return n;
  endfunction

  // One clean press-and-release, then both selectors are checked against the model.
  task automatic press(input bit pu, input bit pd);
    up = pu;
    dn = pd;
    repeat (3) tick();
    up = 1'b0;
    dn = 1'b0;
    repeat (4) tick();
    op_sat = step(op_sat, pu, pd, 1'b1);
    op_wrap = step(op_wrap, pu, pd, 1'b0);
    chk("led_sat", int'(led_s), op_sat);
    chk("led_wrap", int'(led_w), op_wrap);
  endtask

  task automatic goto_op(input int t);
    for (int i = 0; i < 16; i++) begin
      if (op_sat != t) press(op_sat < t, op_sat > t);
    end
    chk("goto_op", int'(led_s), t);
  endtask

  task automatic chk_out(input string name, input logic [W+2:0] exp);
    chk({name, "_valid"}, int'(ov_s), 1);
    chk({name, "_result"}, int'(r_s), int'(exp[W+2:3]));
    chk({name, "_flags"}, int'({c_s, z_s, v_s}), int'(exp[2:0]));
  endtask

  function automatic vec_t mk(input int op, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic [W-1:0] vr, input logic vc, input logic vz,
                              input logic vv);
    vec_t x;
    x.op = op; x.a = va; x.b = vb; x.r = vr; x.c = vc; x.z = vz; x.v = vv;
    return x;
  endfunction

  initial begin
    logic [W+2:0] e;
    logic [W-1:0] last_r;
    int old_s, old_w;

    tbl[0]  = mk(0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1);
    tbl[1]  = mk(0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0);
    tbl[2]  = mk(1, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b1, 1'b0);
    tbl[3]  = mk(1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b1);
    tbl[4]  = mk(1, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(2, 4'b0101, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(3, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(4, 4'b1100, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(5, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(6, 4'b1000, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(6, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(7, 4'b1001, 4'b1001, 4'b0001, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(7, 4'b1001, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0);

    rst = 1'b1; up = 1'b0; dn = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    chk("rst_led", int'(led_s), 0);
    chk("rst_valid", int'(ov_s), 0);
    chk("rst_result", int'(r_s), 0);
    chk("rst_flags", int'({c_s, z_s, v_s}), 0);
    rst = 1'b0;
    repeat (5) tick();

    // Ends of the op selector: clamping versus wrapping.
    for (int i = 0; i < 8; i++) press(1'b1, 1'b0);
    chk("wrap_8up", int'(led_w), 0);
    press(1'b1, 1'b0);
    chk("sat_9up", int'(led_s), 7);
    for (int i = 0; i < 9; i++) press(1'b0, 1'b1);
    chk("sat_9dn", int'(led_s), 0);
    chk("wrap_9dn", int'(led_w), 0);
    press(1'b0, 1'b1);
    chk("wrap_dn_from0", int'(led_w), 7);

    // Held button: one step, two edges after it is first sampled.
    old_s = op_sat;
    old_w = op_wrap;
    up = 1'b1;
    tick();
    tick();
    chk("lat_k1_sat", int'(led_s), old_s);
    chk("lat_k1_wrap", int'(led_w), old_w);
    tick();
    op_sat = step(op_sat, 1'b1, 1'b0, 1'b1);
    op_wrap = step(op_wrap, 1'b1, 1'b0, 1'b0);
    chk("lat_k2_sat", int'(led_s), op_sat);
    chk("lat_k2_wrap", int'(led_w), op_wrap);
    repeat (17) tick();
    chk("held_sat", int'(led_s), op_sat);
    chk("held_wrap", int'(led_w), op_wrap);
    up = 1'b0;
    repeat (4) tick();

    // Both buttons in the same cycle.
    up = 1'b1;
    dn = 1'b1;
    repeat (5) tick();
    chk("both_sat", int'(led_s), op_sat);
    chk("both_wrap", int'(led_w), op_wrap);
    up = 1'b0;
    dn = 1'b0;
    repeat (4) tick();

    // Reset pulsed while up is held.
    up = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    op_sat = 0;
    op_wrap = 0;
    repeat (10) tick();
    chk("rsthold_sat", int'(led_s), 0);
    chk("rsthold_wrap", int'(led_w), 0);
    up = 1'b0;
    repeat (4) tick();
    press(1'b1, 1'b0);

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      goto_op(tbl[i].op);
      a = tbl[i].a;
      b = tbl[i].b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk_out($sformatf("tbl%0d", i), {tbl[i].r, tbl[i].c, tbl[i].z, tbl[i].v});
      tick();
      chk("tbl_valid_drop", int'(ov_s), 0);
      chk("tbl_hold", int'(r_s), int'(tbl[i].r));
    end

    // Streaming AND, one result per cycle.
    goto_op(3);
    a = 4'b1111;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = 4'b0001 << i;
      tick();
      chk_out("stream", {b, 1'b0, 1'b0, 1'b0});
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drop", int'(ov_s), 0);
    chk("stream_hold", int'(r_s), 8);

    // An op change on the capture edge applies only from the next capture.
    goto_op(0);
    a = 4'b0010;
    b = 4'b0001;
    up = 1'b1;
    tick();
    tick();
    in_valid = 1'b1;
    tick();
    chk_out("opchg_old", ref_alu(0, a, b));
    tick();
    chk_out("opchg_new", ref_alu(1, a, b));
    in_valid = 1'b0;
    up = 1'b0;
    op_sat = 1;
    op_wrap = 1;
    repeat (4) tick();

    // Randomised vectors against the reference model.
    for (int g = 0; g < 8; g++) begin
      goto_op(int'($urandom_range(0, 7)));
      in_valid = 1'b1;
      last_r = '0;
      for (int i = 0; i < 6; i++) begin
        a = W'($urandom);
        b = W'($urandom);
        e = ref_alu(op_sat, a, b);
        last_r = e[W+2:3];
        tick();
        chk_out($sformatf("rnd_op%0d", op_sat), e);
      end
      in_valid = 1'b0;
      tick();
      chk("rnd_drop", int'(ov_s), 0);
      chk("rnd_hold", int'(r_s), int'(last_r));
    end

    // Reset during a capture discards the pending result.
    goto_op(4);
    a = 4'b1010;
    b = 4'b0101;
    in_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_valid", int'(ov_s), 0);
    chk("midrst_result", int'(r_s), 0);
    chk("midrst_led", int'(led_s), 0);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
    chk("midrst_after", int'(ov_s), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
